// File: rtl/raster_pkg.sv
// Shared types and layout constants for the raster_dispatch triangle scheduler.
package raster_pkg;

  typedef enum logic [2:0] {
    RESYNC,
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    EOT
  } state_t;

  // Vertex word: {y, x}, each 28.4 fixed point.
  localparam int VTX_W     = 64;
  localparam int COORD_W   = 32;
  localparam int VTX_X_LSB = 0;
  localparam int VTX_Y_LSB = 32;

  // Span word: {y[15:0], x[15:0]}.
  localparam int SPAN_W       = 32;
  localparam int SPAN_COORD_W = 16;
  localparam int SPAN_X_LSB   = 0;
  localparam int SPAN_Y_LSB   = 16;

endpackage

// File: rtl/span_fifo.sv
// Show-ahead FIFO: the head entry is presented combinationally while out_valid is high.
module span_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 41,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    free
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_pop;
  logic             do_push;

  // A push into a full FIFO is only taken when a pop frees a slot the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign free      = CW'(DEPTH) - count;

endmodule

// File: rtl/raster_dispatch.sv
// Triangle scheduler: launches lr_gen one triangle at a time and queues its spans plus a tagged marker.
module raster_dispatch
  import raster_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int TAG_W      = 8,
  parameter int LAUNCH_MIN = 32,
  parameter int START_CYC  = 2,
  parameter int BUSY_TO    = 16,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tri_valid,
  output logic              tri_ready,
  input  logic [VTX_W-1:0]  tri_v1,
  input  logic [VTX_W-1:0]  tri_v2,
  input  logic [VTX_W-1:0]  tri_v3,
  input  logic [TAG_W-1:0]  tri_tag,
  output logic              rast_start,
  output logic [VTX_W-1:0]  rast_v1,
  output logic [VTX_W-1:0]  rast_v2,
  output logic [VTX_W-1:0]  rast_v3,
  input  logic              rast_done,
  input  logic              rast_fifo_write,
  input  logic [SPAN_W-1:0] rast_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SPAN_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_eot,
  output logic              busy,
  output logic              err_timeout,
  output logic              err_ovf,
  input  logic              err_clr
);

  localparam int FW      = $clog2(DEPTH) + 1;
  localparam int WIDTH   = 33 + TAG_W;
  localparam int CYC_MAX = (START_CYC > BUSY_TO) ? START_CYC : BUSY_TO;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  state_t            state;
  state_t            state_nx;
  logic [CYC_W-1:0]  cyc;
  logic              cyc_clr;
  logic [TAG_W-1:0]  tag;
  logic [CNT_W-1:0]  span_cnt;
  logic [FW-1:0]     free;
  logic              pop;
  logic              full;
  logic              fifo_room;
  logic              push;
  logic [WIDTH-1:0]  push_data;
  logic [WIDTH-1:0]  head;
  logic              accept;
  logic              span_in;
  logic              timeout;

  assign pop       = out_valid && out_ready;
  assign full      = (free == '0);
  assign fifo_room = !full || pop;
  assign tri_ready = (state == IDLE) && (free >= FW'(LAUNCH_MIN));
  assign accept    = tri_valid && tri_ready;
  assign span_in   = (state == WAIT_DONE) && rast_fifo_write;
  assign timeout   = (state == WAIT_BUSY) && rast_done && (cyc == CYC_W'(BUSY_TO - 1));
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx   = state;
    push       = 1'b0;
    push_data  = {tag, 1'b0, rast_p};
    rast_start = 1'b0;
    cyc_clr    = 1'b1;
    case (state)
      RESYNC:    if (rast_done) state_nx = IDLE;
      IDLE:      if (accept) state_nx = START;
      START: begin
        rast_start = 1'b1;
        if (cyc == CYC_W'(START_CYC - 1)) state_nx = WAIT_BUSY;
        else cyc_clr = 1'b0;
      end
      WAIT_BUSY: begin
        if (!rast_done)   state_nx = WAIT_DONE;
        else if (timeout) state_nx = EOT;
        else              cyc_clr  = 1'b0;
      end
      WAIT_DONE: begin
        // A span arriving with rast_done still gets pushed on the way out.
        push = rast_fifo_write;
        if (rast_done) state_nx = EOT;
      end
      EOT: begin
        push      = 1'b1;
        push_data = {tag, 1'b1, 32'(span_cnt)};
        if (fifo_room) state_nx = IDLE;
      end
      default:   state_nx = RESYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RESYNC;
      cyc         <= '0;
      tag         <= '0;
      span_cnt    <= '0;
      rast_v1     <= '0;
      rast_v2     <= '0;
      rast_v3     <= '0;
      err_timeout <= 1'b0;
      err_ovf     <= 1'b0;
    end else begin
      state <= state_nx;
      cyc   <= cyc_clr ? '0 : cyc + 1'b1;
      if (accept) begin
        tag      <= tri_tag;
        span_cnt <= '0;
        rast_v1  <= tri_v1;
        rast_v2  <= tri_v2;
        rast_v3  <= tri_v3;
      end else if (span_in && (span_cnt != '1)) begin
        span_cnt <= span_cnt + 1'b1;
      end
      if (timeout)      err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
      if (span_in && full && !pop) err_ovf <= 1'b1;
      else if (err_clr)            err_ovf <= 1'b0;
    end
  end

  span_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (out_ready),
    .out_valid (out_valid),
    .out_data  (head),
    .free      (free)
  );

  assign {out_tag, out_eot, out_data} = head;

endmodule

// File: tb/tb_raster_dispatch.sv
// Directed bench for raster_dispatch: table-driven triangles plus hand-written corner sequences.
module tb_raster_dispatch;
  import raster_pkg::*;

  localparam int TAG_W     = 8;
  localparam int START_CYC = 2;
  localparam int BUSY_TO   = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              tri_valid;
  logic              tri_ready;
  logic [VTX_W-1:0]  tri_v1, tri_v2, tri_v3;
  logic [TAG_W-1:0]  tri_tag;
  logic              rast_start;
  logic [VTX_W-1:0]  rast_v1, rast_v2, rast_v3;
  logic              rast_done;
  logic              rast_fifo_write;
  logic [SPAN_W-1:0] rast_p;
  logic              out_valid;
  logic              out_ready;
  logic [SPAN_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_eot;
  logic              busy;
  logic              err_timeout;
  logic              err_ovf;
  logic              err_clr;

  raster_dispatch #(
    .DEPTH(4), .TAG_W(TAG_W), .LAUNCH_MIN(1),
    .START_CYC(START_CYC), .BUSY_TO(BUSY_TO), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .tri_valid(tri_valid), .tri_ready(tri_ready),
    .tri_v1(tri_v1), .tri_v2(tri_v2), .tri_v3(tri_v3), .tri_tag(tri_tag),
    .rast_start(rast_start), .rast_v1(rast_v1), .rast_v2(rast_v2), .rast_v3(rast_v3),
    .rast_done(rast_done), .rast_fifo_write(rast_fifo_write), .rast_p(rast_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_eot(out_eot),
    .busy(busy), .err_timeout(err_timeout), .err_ovf(err_ovf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]       tag;
    int               n;
    logic [7:0][31:0] sp;
    bit               same;
    int               cnt;
  } vec_t;

  vec_t        tbl [4];
  logic [40:0] got [$];
  int          checks = 0;
  int          errors = 0;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got.push_back({out_eot, out_tag, out_data});
  end

  function automatic logic [31:0] mk_span(input logic [SPAN_COORD_W-1:0] y,
                                          input logic [SPAN_COORD_W-1:0] x);
    return (32'(y) << SPAN_Y_LSB) | (32'(x) << SPAN_X_LSB);
  endfunction

  function automatic logic [63:0] mk_vtx(input logic [COORD_W-1:0] y, input logic [COORD_W-1:0] x);
    return (64'(y) << VTX_Y_LSB) | (64'(x) << VTX_X_LSB);
  endfunction

  function automatic vec_t mk_rec(input logic [7:0] tg, input int n, input logic [31:0] s0,
                                  input logic [31:0] s1, input logic [31:0] s2,
                                  input logic [31:0] s3, input bit same, input int cnt);
    vec_t r;
    r.tag  = tg;
    r.n    = n;
    r.sp   = '0;
    r.sp[0] = s0;
    r.sp[1] = s1;
    r.sp[2] = s2;
    r.sp[3] = s3;
    r.same = same;
    r.cnt  = cnt;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_tri(input logic [7:0] tg, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c);
    int g = 0;
    tri_valid = 1'b1;
    tri_tag   = tg;
    tri_v1    = a;
    tri_v2    = b;
    tri_v3    = c;
    while (!tri_ready && g < 100) begin
      tick();
      g++;
    end
    check("tri_ready_wait", tri_ready, 1);
    tick();
    tri_valid = 1'b0;
    check("start_after_accept", rast_start, 1);
    check("rast_v1_latch", rast_v1, a);
    check("rast_v2_latch", rast_v2, b);
    check("rast_v3_latch", rast_v3, c);
  endtask

  // Rasterizer model: goes busy after the start pulse, emits n spans, then goes idle.
  task automatic rast_run(input int n, input logic [7:0][31:0] sp, input bit same);
    int g = 0;
    while (rast_start && g < 10) begin
      tick();
      g++;
    end
    check("start_len", g, START_CYC);
    rast_done = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      rast_fifo_write = 1'b1;
      rast_p          = sp[i];
      if (same && i == n - 1) rast_done = 1'b1;
      tick();
    end
    rast_fifo_write = 1'b0;
    rast_p          = '0;
    if (!rast_done) begin
      rast_done = 1'b1;
      tick();
    end
  endtask

  task automatic wait_got(input int n);
    int g = 0;
    while (got.size() < n && g < 100) begin
      tick();
      g++;
    end
    check("drain_count", got.size(), n);
  endtask

  task automatic check_span(input int i, input logic [31:0] d, input logic [7:0] tg);
    logic [40:0] e;
    if (i < got.size()) begin
      e = got[i];
      check("span_data", e[31:0], d);
      check("span_tag", e[39:32], tg);
      check("span_eot", e[40], 0);
    end
  endtask

  task automatic check_mark(input int i, input int cnt, input logic [7:0] tg);
    logic [40:0] e;
    if (i < got.size()) begin
      e = got[i];
      check("mark_count", e[31:0], cnt);
      check("mark_tag", e[39:32], tg);
      check("mark_eot", e[40], 1);
    end
  endtask

  initial begin
    logic [7:0][31:0] sp6;
    logic [63:0]      va, vb;
    int               k;

    rst_n = 1'b0; tri_valid = 1'b0; tri_tag = '0;
    tri_v1 = '0; tri_v2 = '0; tri_v3 = '0;
    rast_done = 1'b0; rast_fifo_write = 1'b0; rast_p = '0;
    out_ready = 1'b1; err_clr = 1'b0;

    tbl[0] = mk_rec(8'h11, 3, 32'h00050002, 32'h00060002, 32'h00070003, 32'h0, 1'b0, 3);
    tbl[1] = mk_rec(8'hA5, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 0);
    tbl[2] = mk_rec(8'h42, 2, mk_span(16'd3, 16'd4), mk_span(16'hFFFF, 16'hFFFF),
                    32'h0, 32'h0, 1'b1, 2);
    tbl[3] = mk_rec(8'h7E, 4, mk_span(16'd10, 16'd1), mk_span(16'd11, 16'd2),
                    mk_span(16'd12, 16'd3), mk_span(16'd13, 16'd4), 1'b0, 4);

    // Reset values
    repeat (2) tick();
    check("rst_tri_ready", tri_ready, 0);
    check("rst_rast_start", rast_start, 0);
    check("rst_rast_v1", rast_v1, 0);
    check("rst_rast_v2", rast_v2, 0);
    check("rst_rast_v3", rast_v3, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_eot", out_eot, 0);
    check("rst_busy", busy, 1);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_err_ovf", err_ovf, 0);

    // Resync: rasterizer still busy after reset release
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("resync_hold", tri_ready, 0);
    end
    rast_done = 1'b1;
    tick();
    check("resync_ready", tri_ready, 1);
    check("resync_idle", busy, 0);

    // Table of triangles drained with out_ready held high
    for (int i = 0; i < 4; i++) begin
      got.delete();
      run_tri(tbl[i].tag, mk_vtx(32'(i + 1), 32'(tbl[i].tag)),
              mk_vtx(32'h100, 32'(i)), mk_vtx(32'hFFFF_FFF0, 32'h8000_0000));
      rast_run(tbl[i].n, tbl[i].sp, tbl[i].same);
      wait_got(tbl[i].n + 1);
      for (int j = 0; j < tbl[i].n; j++) check_span(j, tbl[i].sp[j], tbl[i].tag);
      check_mark(tbl[i].n, tbl[i].cnt, tbl[i].tag);
      check("tbl_no_ovf", err_ovf, 0);
      check("tbl_idle", busy, 0);
    end

    // Rasterizer never goes busy
    got.delete();
    run_tri(8'h99, mk_vtx(32'd1, 32'd2), mk_vtx(32'd3, 32'd4), mk_vtx(32'd5, 32'd6));
    k = 0;
    while (!err_timeout && k < 100) begin
      tick();
      k++;
    end
    check("timeout_cycles", k, START_CYC + BUSY_TO);
    wait_got(1);
    check_mark(0, 0, 8'h99);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("timeout_clr", err_timeout, 0);

    // Overflow: 6 spans into a 4-deep FIFO with downstream stalled
    got.delete();
    out_ready = 1'b0;
    sp6 = '0;
    for (int i = 0; i < 6; i++) sp6[i] = mk_span(16'(20 + i), 16'(i));
    run_tri(8'h66, mk_vtx(32'd7, 32'd8), mk_vtx(32'd9, 32'd10), mk_vtx(32'd11, 32'd12));
    rast_run(6, sp6, 1'b0);
    check("ovf_set", err_ovf, 1);
    repeat (3) tick();
    check("ovf_stall_busy", busy, 1);
    check("ovf_head_valid", out_valid, 1);
    check("ovf_head_eot", out_eot, 0);
    check("ovf_head_data", out_data, sp6[0]);
    out_ready = 1'b1;
    wait_got(5);
    for (int j = 0; j < 4; j++) check_span(j, sp6[j], 8'h66);
    check_mark(4, 6, 8'h66);
    check("ovf_idle", busy, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ovf_clr", err_ovf, 0);

    // Back-to-back triangles with tri_valid held high
    got.delete();
    va = mk_vtx(32'hA, 32'hA);
    vb = mk_vtx(32'hB, 32'hB);
    sp6 = '0;
    sp6[0] = mk_span(16'd30, 16'd31);
    tri_valid = 1'b1; tri_tag = 8'h01; tri_v1 = va; tri_v2 = va; tri_v3 = va;
    k = 0;
    while (!tri_ready && k < 100) begin
      tick();
      k++;
    end
    tick();
    tri_tag = 8'h02; tri_v1 = vb; tri_v2 = vb; tri_v3 = vb;
    check("b2b_v1_first", rast_v1, va);
    rast_run(1, sp6, 1'b0);
    check("b2b_ready_in_eot", tri_ready, 0);
    check("b2b_v1_hold", rast_v1, va);
    tick();
    check("b2b_ready_idle", tri_ready, 1);
    check("b2b_idle", busy, 0);
    check("b2b_v1_still", rast_v1, va);
    check("b2b_marker_head", {out_valid, out_eot, out_tag}, {1'b1, 1'b1, 8'h01});
    tick();
    tri_valid = 1'b0;
    check("b2b_v1_second", rast_v1, vb);
    check("b2b_v3_second", rast_v3, vb);
    check("b2b_start2", rast_start, 1);
    rast_run(0, sp6, 1'b0);
    wait_got(3);
    check_span(0, sp6[0], 8'h01);
    check_mark(1, 1, 8'h01);
    check_mark(2, 0, 8'h02);

    // Reset in the middle of a triangle
    got.delete();
    run_tri(8'h77, mk_vtx(32'd1, 32'd1), mk_vtx(32'd2, 32'd2), mk_vtx(32'd3, 32'd3));
    out_ready = 1'b0;
    k = 0;
    while (rast_start && k < 10) begin
      tick();
      k++;
    end
    rast_done = 1'b0;
    tick();
    rast_fifo_write = 1'b1;
    rast_p = mk_span(16'd40, 16'd41);
    tick();
    rast_fifo_write = 1'b0;
    check("mid_span_stored", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 1);
    check("mid_rst_rast_v1", rast_v1, 0);
    check("mid_rst_start", rast_start, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();
    check("mid_resync_hold", tri_ready, 0);
    rast_done = 1'b1;
    tick();
    check("mid_resync_ready", tri_ready, 1);
    check("mid_no_marker", out_valid, 0);
    check("mid_nothing_out", got.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/raster_dispatch.md
# raster_dispatch

Triangle scheduler for the `lr_gen` span rasterizer.
- Accepts triangle commands over a valid/ready port and launches the rasterizer one triangle at a time.
- Captures every span the rasterizer emits into an internal FIFO that downstream drains under backpressure.
- Ends each triangle with a tagged end-of-triangle marker.

It sits between the command front-end and the span fill stage.

## Interface
- DEPTH, 64: span FIFO entries; power of 2, at least 4.
- TAG_W, 8: triangle tag width.
- LAUNCH_MIN, 32: minimum FIFO free entries required before a triangle is accepted.
- START_CYC, 2: cycles `rast_start` is held high per launch.
- BUSY_TO, 16: cycles allowed for `rast_done` to fall after the start pulse ends.
- CNT_W, 16: per-triangle span counter width; must be at most 32.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- tri_valid  in  1  triangle command valid
- tri_ready  out  1  triangle command accepted this cycle when high with `tri_valid`
- tri_v1, tri_v2, tri_v3  in  64 each  vertices: {y[63:32], x[31:0]}, 28.4 fixed point
- tri_tag  in  TAG_W  triangle tag
- rast_start  out  1  rasterizer start pulse
- rast_v1, rast_v2, rast_v3  out  64 each  latched vertices to the rasterizer
- rast_done  in  1  rasterizer idle (high) / busy (low)
- rast_fifo_write  in  1  span valid strobe
- rast_p  in  32  span {y[15:0], x[15:0]}
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream pop
- out_data  out  32  span, or span count (zero-extended) when `out_eot` is high
- out_tag  out  TAG_W  tag of the entry
- out_eot  out  1  entry is an end-of-triangle marker
- busy  out  1  controller not idle
- err_timeout  out  1  sticky: rasterizer never went busy
- err_ovf  out  1  sticky: span dropped because the FIFO was full
- err_clr  in  1  clears both sticky errors

## Operation
- States and transitions:
  - RESYNC: entered from reset. Waits for `rast_done==1`, because the rasterizer has no reset. Then go to IDLE.
  - IDLE: `tri_ready = (free >= LAUNCH_MIN)`. On accept, latch vertices and tag, clear span_cnt, go to START.
  - START: `rast_start=1` for START_CYC cycles, then go to WAIT_BUSY.
  - WAIT_BUSY:
    - `rast_done==0`: go to WAIT_DONE.
    - BUSY_TO cycles elapse first: set `err_timeout`, go to EOT.
  - WAIT_DONE: each `rast_fifo_write` pushes {tag, eot=0, `rast_p`} and increments span_cnt. `rast_done==1` goes to EOT. A span strobe in the same cycle as `rast_done` rising is pushed before the transition.
  - EOT: push {tag, eot=1, span_cnt}. If the FIFO is full, stall here; a marker is never dropped. Then go to IDLE.
- `rast_v*` hold their value from the cycle after accept until the next accept.
- Overflow:
  - A span push when full and no pop that cycle drops the span and sets `err_ovf`.
  - span_cnt still increments; it counts generated spans.
  - A push with a simultaneous pop when full is accepted.
- span_cnt saturates at 2^CNT_W−1.
- Sticky errors are cleared by `err_clr`. If `err_clr` and a set condition coincide, the set wins.
- `busy = (state != IDLE)`.

## Timing
- Reset values:
  - state RESYNC, `tri_ready` 0, `rast_start` 0, `rast_v*` 0.
  - `out_valid` 0, `out_data`/`out_tag`/`out_eot` 0.
  - `busy` 1, `err_*` 0, FIFO empty.
- Reset asserted mid-triangle: everything returns to the reset values, FIFO is flushed, no EOT marker is emitted, and RESYNC waits out the running triangle.
- Accept at edge N: `rast_start` is high on cycles N+1 .. N+START_CYC.
- FIFO:
  - Push-to-`out_valid` latency is 1 cycle.
  - Show-ahead: the head is valid while `out_valid` is high.
  - A pop occurs on `out_valid && out_ready`.
- `tri_ready` is combinational from state and free count only; it never depends on `tri_valid`.
- Minimum triangle turnaround is START_CYC + 4 cycles.

## Structure
- Shared package `raster_pkg`:
  - state enum (RESYNC, IDLE, START, WAIT_BUSY, WAIT_DONE, EOT);
  - span field offsets and the vertex layout constants.
- Sub-module `span_fifo`: synchronous show-ahead FIFO with `rst_n`, parameters DEPTH and WIDTH (WIDTH = 33+TAG_W), exposing a free-count output.

## Test plan
- Reset release with `rast_done=0` for 5 cycles: `tri_ready` stays 0 until `rast_done` rises.
- Triangle tag 0x11 that yields 3 spans (0x00050002, 0x00060002, 0x00070003), `out_ready=1`: FIFO outputs the 3 spans with tag 0x11, then a marker with `out_eot=1`, `out_data=3`.
- `rast_done` stays 1 after the start pulse: after START_CYC+BUSY_TO cycles, `err_timeout`=1 and a marker with count 0 is emitted.
- DEPTH=4, LAUNCH_MIN=1, `out_ready=0`, 6 spans: 4 stored, `err_ovf`=1, marker stalls in EOT until `out_ready`=1, marker count 6.
- Span strobe in the same cycle `rast_done` rises: span is stored, followed by a marker with the correct count.
- Back-to-back triangles with tags 1 and 2: second `tri_ready` only in IDLE after the first marker; `rast_v*` change only after the second accept.
